// File: rtl/arm_shift_pkg.sv
// arm_shift_pkg: shift-type and FSM-state encodings shared by the shifter arbiter files
package arm_shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
  localparam int AMT_W = 8;
endpackage

// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if: two request ports plus one response channel of the shared shifter
interface shifter_arbiter_if import arm_shift_pkg::*; #(parameter int DATA_LEN = 32);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [DATA_LEN-1:0] req_operand [2];
  shift_t              req_type    [2];
  logic [AMT_W-1:0]    req_amount  [2];
  logic                carry_in;
  logic                flush;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_data;
  logic                resp_carry;
  logic                resp_id;
  modport slave (
    input  req_valid, req_operand, req_type, req_amount, carry_in, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_carry, resp_id
  );
  modport master (
    output req_valid, req_operand, req_type, req_amount, carry_in, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_carry, resp_id
  );
endinterface

// File: rtl/shifter_arbiter_shift_core.sv
// shift_core: combinational ARM-style barrel shifter with register-specified amount and carry-out
module shift_core import arm_shift_pkg::*; #(parameter int DATA_LEN = 32) (
  input  logic [DATA_LEN-1:0] i_operand,
  input  shift_t              i_type,
  input  logic [AMT_W-1:0]    i_amount,
  input  logic                i_carry,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_carry
);
  localparam int RW = $clog2(DATA_LEN);
  logic [DATA_LEN:0]   w_lsl;
  logic [DATA_LEN:0]   w_lsr;
  logic [DATA_LEN:0]   w_asr;
  logic [DATA_LEN-1:0] w_rot;
  logic [RW-1:0]       w_ramt;
  // one guard bit beside the operand catches the last bit shifted out, so large amounts fall out naturally
  always_comb begin
    w_ramt = i_amount[RW-1:0];
    w_rot = (i_operand >> w_ramt) | (i_operand << (DATA_LEN - int'(w_ramt)));
    w_lsl = {1'b0, i_operand} << i_amount;
    w_lsr = {i_operand, 1'b0} >> i_amount;
    w_asr = $signed({i_operand, 1'b0}) >>> i_amount;
    {o_carry, o_data} = i_amount == '0        ? {i_carry, i_operand} :
                        i_type == SHIFT_LSL   ? w_lsl :
                        i_type == SHIFT_LSR   ? {w_lsr[0], w_lsr[DATA_LEN:1]} :
                        i_type == SHIFT_ASR   ? {w_asr[0], w_asr[DATA_LEN:1]} :
                                                {w_rot[DATA_LEN-1], w_rot};
  end
endmodule

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin two-port front end sharing one shifter behind a single result register
module shifter_arbiter import arm_shift_pkg::*; #(parameter int DATA_LEN = 32) (
  input logic              clk,
  input logic              rst_n,
  shifter_arbiter_if.slave bus
);
  state_t              r_state;
  logic                r_last;
  logic [DATA_LEN-1:0] r_data;
  logic                r_carry;
  logic                r_id;
  logic                w_open;
  logic [1:0]          w_ready;
  logic                w_grant;
  logic [DATA_LEN-1:0] w_data;
  logic                w_carry;
  // ready depends only on state and control, never on request payload
  always_comb begin
    w_open = rst_n && !bus.flush && (r_state == ST_EMPTY || bus.resp_ready);
    w_ready[0] = w_open && bus.req_valid[0] && (!bus.req_valid[1] || r_last);
    w_ready[1] = w_open && bus.req_valid[1] && (!bus.req_valid[0] || !r_last);
    w_grant = w_ready[1];
  end
  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_state == ST_FULL;
  assign bus.resp_data  = r_data;
  assign bus.resp_carry = r_carry;
  assign bus.resp_id    = r_id;
  shift_core #(.DATA_LEN(DATA_LEN)) u_core (
    .i_operand (bus.req_operand[w_grant]),
    .i_type    (bus.req_type[w_grant]),
    .i_amount  (bus.req_amount[w_grant]),
    .i_carry   (bus.carry_in),
    .o_data    (w_data),
    .o_carry   (w_carry)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_last  <= 1'b1;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
    end else if (bus.flush) begin
      r_state <= ST_EMPTY;
    end else if (|w_ready) begin
      r_state <= ST_FULL;
      r_last  <= w_grant;
      r_data  <= w_data;
      r_carry <= w_carry;
      r_id    <= w_grant;
    end else if (bus.resp_ready) begin
      r_state <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: directed vectors with a response scoreboard for shifter_arbiter
module tb_shifter_arbiter;
  import arm_shift_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] q[$];
  shifter_arbiter_if #(.DATA_LEN(32)) bus();
  shifter_arbiter #(.DATA_LEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got id=%0d c=%0d d=%0h expected no response", bus.resp_id, bus.resp_carry, bus.resp_data);
      end else begin
        check("resp", {30'd0, bus.resp_id, bus.resp_carry, bus.resp_data}, {30'd0, q.pop_front()});
      end
    end
  end

  task automatic step(input string name, input logic [1:0] rdy, input logic c = 1'b0, input logic [31:0] d = 32'd0);
    @(negedge clk);
    check(name, {62'd0, bus.req_ready}, {62'd0, rdy});
    if (|rdy) q.push_back({rdy[1], c, d});
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] op, input shift_t t, input logic [7:0] amt);
    bus.req_operand[p] = op;
    bus.req_type[p] = t;
    bus.req_amount[p] = amt;
  endtask

  task automatic edge_vec(input string name, input int p, input logic [31:0] op, input shift_t t,
                          input logic [7:0] amt, input logic [31:0] d, input logic c);
    set_req(p, op, t, amt);
    bus.req_valid = p == 1 ? 2'b10 : 2'b01;
    step(name, bus.req_valid, c, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b11;
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    bus.carry_in = 1'b0;
    for (int i = 0; i < 2; i++) set_req(i, 32'd0, SHIFT_LSL, 8'd0);
    @(posedge clk);
    #1;
    check("rst_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_data", {32'd0, bus.resp_data}, 64'd0);
    check("rst_carry_id", {62'd0, bus.resp_carry, bus.resp_id}, 64'd0);
    check("rst_ready", {62'd0, bus.req_ready}, 64'd0);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    set_req(0, 32'h0000_00F0, SHIFT_LSR, 8'd4);
    set_req(1, 32'h8000_0000, SHIFT_ROR, 8'd1);
    step("tie0", 2'b01, 1'b0, 32'h0000_000F);
    step("tie1", 2'b10, 1'b0, 32'h4000_0000);
    bus.req_amount[0] = 8'd0;
    bus.carry_in = 1'b1;
    step("tie2", 2'b01, 1'b1, 32'h0000_00F0);
    step("tie3", 2'b10, 1'b0, 32'h4000_0000);
    bus.carry_in = 1'b0;
    bus.req_valid = 2'b00;
    step("idle", 2'b00);
    edge_vec("lsl4",      0, 32'h0000_0001, SHIFT_LSL, 8'd4,  32'h0000_0010, 1'b0);
    edge_vec("asr40",     1, 32'h8000_0000, SHIFT_ASR, 8'd40, 32'hFFFF_FFFF, 1'b1);
    edge_vec("lsr32",     1, 32'h8000_0000, SHIFT_LSR, 8'd32, 32'h0000_0000, 1'b1);
    edge_vec("ror32",     1, 32'h8000_0001, SHIFT_ROR, 8'd32, 32'h8000_0001, 1'b1);
    edge_vec("lsl32",     0, 32'h8000_0001, SHIFT_LSL, 8'd32, 32'h0000_0000, 1'b1);
    edge_vec("lsl33",     0, 32'hFFFF_FFFF, SHIFT_LSL, 8'd33, 32'h0000_0000, 1'b0);
    edge_vec("lsl2",      0, 32'h4000_0000, SHIFT_LSL, 8'd2,  32'h0000_0000, 1'b1);
    edge_vec("asr4",      1, 32'h7000_0000, SHIFT_ASR, 8'd4,  32'h0700_0000, 1'b0);
    edge_vec("asr32",     1, 32'h8000_0000, SHIFT_ASR, 8'd32, 32'hFFFF_FFFF, 1'b1);
    edge_vec("ror33",     1, 32'h0000_0003, SHIFT_ROR, 8'd33, 32'h8000_0001, 1'b1);
    edge_vec("lsr1",      0, 32'h0000_0003, SHIFT_LSR, 8'd1,  32'h0000_0001, 1'b1);
    edge_vec("lsr40",     0, 32'hFFFF_FFFF, SHIFT_LSR, 8'd40, 32'h0000_0000, 1'b0);
    edge_vec("pre_stall", 0, 32'h0000_0005, SHIFT_LSL, 8'd1,  32'h0000_000A, 1'b0);
    bus.resp_ready = 1'b0;
    set_req(1, 32'h0000_0003, SHIFT_LSL, 8'd8);
    bus.req_valid = 2'b10;
    repeat (3) begin
      step("stall_ready", 2'b00);
      check("stall_data", {32'd0, bus.resp_data}, 64'h0000_000A);
      check("stall_valid", {63'd0, bus.resp_valid}, 64'd1);
    end
    bus.resp_ready = 1'b1;
    step("resume", 2'b10, 1'b0, 32'h0000_0300);
    bus.req_valid = 2'b00;
    step("idle", 2'b00);
    edge_vec("pre_flush", 0, 32'h0000_0001, SHIFT_LSL, 8'd1, 32'h0000_0002, 1'b0);
    bus.resp_ready = 1'b0;
    set_req(1, 32'h0000_0001, SHIFT_LSR, 8'd1);
    bus.req_valid = 2'b11;
    step("hold", 2'b00);
    bus.flush = 1'b1;
    step("flush", 2'b00);
    void'(q.pop_front());
    check("flush_valid", {63'd0, bus.resp_valid}, 64'd0);
    bus.flush = 1'b0;
    bus.resp_ready = 1'b1;
    step("after_flush", 2'b10, 1'b1, 32'h0000_0000);
    bus.req_valid = 2'b00;
    step("idle", 2'b00);
    bus.carry_in = 1'b1;
    edge_vec("pre_rst", 0, 32'h0000_0001, SHIFT_LSL, 8'd0, 32'h0000_0001, 1'b1);
    bus.carry_in = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("arst_data", {32'd0, bus.resp_data}, 64'd0);
    check("arst_carry", {63'd0, bus.resp_carry}, 64'd0);
    check("arst_ready", {62'd0, bus.req_ready}, 64'd0);
    void'(q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    step("rst_tie", 2'b01, 1'b0, 32'h0000_0001);
    bus.req_valid = 2'b00;
    step("idle", 2'b00);
    step("idle", 2'b00);
    check("drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
